// File: rtl/fsm_pkg.sv
// Shared definitions for the byte serializer that feeds the bit-serial pattern FSM.
package fsm_pkg;

  localparam int WORD_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ser_shift_reg.sv
// Shift register and bit counter for one word, with first/last bit decode.
module ser_shift_reg
  import fsm_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             bit_out,
  output logic             first,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d, sh_shifted;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The output end is bit 0 for LSB-first and bit WIDTH-1 for MSB-first.
  generate
    if (MSB_FIRST) begin : g_msb
      assign bit_out    = sh_q[WIDTH-1];
      assign sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign bit_out    = sh_q[0];
      assign sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
    end
  endgenerate

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == CNT_LAST);

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = load_data;
      cnt_d = '0;
    end else if (shift_en) begin
      sh_d  = sh_shifted;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fsm_byte_serializer.sv
// Parallel-to-serial feeder: valid/ready word input, one bit per handshake out,
// with a one-entry pending buffer so consecutive words stream without a gap.
module fsm_byte_serializer
  import fsm_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_first,
  output logic             bit_last,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;

  logic             load, shift_en;
  logic [WIDTH-1:0] load_data;
  logic             sr_bit, sr_first, sr_last;
  logic             shifting, in_xfer, bit_xfer, last_xfer;

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .shift_en  (shift_en),
    .bit_out   (sr_bit),
    .first     (sr_first),
    .last      (sr_last)
  );

  assign shifting  = (state_q == ST_SHIFT);
  assign in_ready  = !pend_v_q;
  assign in_xfer   = in_valid && in_ready;
  assign bit_xfer  = shifting && bit_ready;
  assign last_xfer = bit_xfer && sr_last;

  assign bit_valid = shifting;
  assign bit_out   = shifting && sr_bit;
  assign bit_first = shifting && sr_first;
  assign bit_last  = shifting && sr_last;
  assign busy      = shifting || pend_v_q;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    load      = 1'b0;
    load_data = in_data;
    shift_en  = 1'b0;

    if (state_q == ST_IDLE) begin
      if (in_xfer) begin
        load    = 1'b1;
        state_d = ST_SHIFT;
      end
    end else if (last_xfer) begin
      // The pending word has priority; in_ready is low whenever it exists.
      if (pend_v_q) begin
        load      = 1'b1;
        load_data = pend_q;
        pend_v_d  = 1'b0;
      end else if (in_xfer) begin
        load = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      shift_en = bit_xfer;
      if (in_xfer) begin
        pend_d   = in_data;
        pend_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

endmodule

// File: tb/tb_fsm_byte_serializer.sv
// Drives an LSB-first and an MSB-first serializer with identical stimulus and
// checks every cycle against a word-queue model of the expected bit stream.
module tb_fsm_byte_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         bit_ready;

  logic [1:0] in_ready_o, bit_out_o, bit_valid_o, bit_first_o, bit_last_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  // Per DUT: words accepted but not fully sent (head is on the wire), and bit index of head.
  int m_words[2][2];
  int m_n[2];
  int m_idx[2];

  always #5 clk = ~clk;

  fsm_byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_o[0]),
    .bit_out   (bit_out_o[0]),
    .bit_valid (bit_valid_o[0]),
    .bit_ready (bit_ready),
    .bit_first (bit_first_o[0]),
    .bit_last  (bit_last_o[0]),
    .busy      (busy_o[0])
  );

  fsm_byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_o[1]),
    .bit_out   (bit_out_o[1]),
    .bit_valid (bit_valid_o[1]),
    .bit_ready (bit_ready),
    .bit_first (bit_first_o[1]),
    .bit_last  (bit_last_o[1]),
    .busy      (busy_o[1])
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_bit(input int m);
    int w;
    int i;
    w = m_words[m][0];
    i = m_idx[m];
    if (m == 1) return (w >> (W - 1 - i)) & 1;
    return (w >> i) & 1;
  endfunction

  function automatic string pfx(input int m);
    return (m == 0) ? "lsb" : "msb";
  endfunction

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      check_eq({pfx(m), " in_ready"},  in_ready_o[m],  (m_n[m] < 2) ? 1 : 0);
      check_eq({pfx(m), " busy"},      busy_o[m],      (m_n[m] > 0) ? 1 : 0);
      check_eq({pfx(m), " bit_valid"}, bit_valid_o[m], (m_n[m] > 0) ? 1 : 0);
      if (m_n[m] > 0) begin
        check_eq({pfx(m), " bit_out"},   bit_out_o[m],   exp_bit(m));
        check_eq({pfx(m), " bit_first"}, bit_first_o[m], (m_idx[m] == 0) ? 1 : 0);
        check_eq({pfx(m), " bit_last"},  bit_last_o[m],  (m_idx[m] == W - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic update_model(input logic v, input logic [W-1:0] d, input logic r);
    bit rdy;
    for (int m = 0; m < 2; m++) begin
      rdy = (m_n[m] < 2);
      if (m_n[m] > 0 && r) begin
        m_idx[m]++;
        if (m_idx[m] == W) begin
          $display("%s word 0x%02h sent", pfx(m), m_words[m][0]);
          m_words[m][0] = m_words[m][1];
          m_n[m]--;
          m_idx[m] = 0;
        end
      end
      if (v && rdy) begin
        m_words[m][m_n[m]] = int'(d);
        m_n[m]++;
      end
    end
  endtask

  // One clock cycle: drive, check on the falling edge, advance the model on the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    bit_ready = r;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model(v, d, r);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check_eq({pfx(m), " rst bit_valid"}, bit_valid_o[m], 0);
      check_eq({pfx(m), " rst bit_out"},   bit_out_o[m],   0);
      check_eq({pfx(m), " rst bit_first"}, bit_first_o[m], 0);
      check_eq({pfx(m), " rst bit_last"},  bit_last_o[m],  0);
      check_eq({pfx(m), " rst busy"},      busy_o[m],      0);
      check_eq({pfx(m), " rst in_ready"},  in_ready_o[m],  1);
      m_n[m]   = 0;
      m_idx[m] = 0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int pv;
    int pr;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    bit_ready = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();
    step(1'b0, '0, 1'b1);

    // Single word, LSB/MSB streams of 23
    step(1'b1, 8'd23, 1'b1);
    repeat (9) step(1'b0, '0, 1'b1);

    // Back-to-back 23 then 170, plus a word offered while the buffer is full
    step(1'b1, 8'd23, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b1, 8'd170, 1'b1);
    step(1'b1, 8'd99, 1'b1);
    repeat (14) step(1'b0, '0, 1'b1);

    // Stall at bit index 3 of 74
    step(1'b1, 8'd74, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1);

    // 110 exercises the MSB-first ordering on the second DUT
    step(1'b1, 8'd110, 1'b1);
    repeat (9) step(1'b0, '0, 1'b1);

    // Reset mid-word with a pending word, then a clean 65
    step(1'b1, 8'd200, 1'b1);
    step(1'b1, 8'd122, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1);
    apply_reset();
    step(1'b1, 8'd65, 1'b1);
    repeat (9) step(1'b0, '0, 1'b1);

    // Last-bit transfer and a new word in the same cycle
    step(1'b1, 8'd23, 1'b1);
    repeat (7) step(1'b0, '0, 1'b1);
    step(1'b1, 8'd33, 1'b1);
    repeat (9) step(1'b0, '0, 1'b1);

    // Randomized traffic with varying input and output pressure
    pv = 50;
    pr = 50;
    for (int c = 0; c < 2500; c++) begin
      if (c % 250 == 0) begin
        pv = int'($urandom_range(10, 100));
        pr = int'($urandom_range(10, 100));
      end
      if ($urandom_range(0, 499) == 0) begin
        apply_reset();
      end else begin
        step(($urandom_range(0, 99) < pv), W'($urandom), ($urandom_range(0, 99) < pr));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_byte_serializer.md
Name: fsm_byte_serializer

Overview:
Upstream feeder for the bit-serial pattern FSM. It accepts parallel bytes over a valid/ready handshake and shifts each byte out one bit per handshake, with frame markers on the first and last bit. The FSM consumes the bit stream and builds its output byte. A one-entry pending buffer lets back-to-back bytes stream with no idle cycle.

Parameters:
WIDTH, 8, bits per input word (at least 2)
MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit WIDTH-1 sent first

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_data  input  WIDTH  parallel word
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word
bit_out  output  1  current serial bit
bit_valid  output  1  bit_out is valid
bit_ready  input  1  downstream FSM accepts bit_out
bit_first  output  1  bit_out is the first bit of a word
bit_last  output  1  bit_out is the last bit of a word
busy  output  1  shifting in progress or a word is pending

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low. All state clears on rst_n low, with no wait for a clock edge.
- Reset values: bit_valid=0, bit_out=0, bit_first=0, bit_last=0, busy=0, in_ready=1, pending buffer empty, bit count=0, state IDLE.
- Handshakes: input transfer occurs when in_valid && in_ready at a rising edge. Bit transfer occurs when bit_valid && bit_ready at a rising edge.
- Storage: shift register `sh`, bit counter `cnt` of width clog2(WIDTH), pending register `pend` with flag `pend_v`.
- in_ready = !pend_v. This is a registered flag, so there is no combinational path from bit_ready to in_ready.
- FSM has two states, IDLE and SHIFT.
  - IDLE: bit_valid=0. On an input transfer, load sh from in_data, set cnt=0, go to SHIFT. The first bit is valid the next cycle, so latency is 1 cycle.
  - SHIFT: bit_valid=1.
    - bit_out = sh[0] (LSB-first) or sh[WIDTH-1] (MSB-first).
    - bit_first = (cnt==0).
    - bit_last = (cnt==WIDTH-1).
    - A bit transfer that is not the last bit shifts sh by one toward the output end and increments cnt.
  - Last-bit transfer:
    - if pend_v: load sh from pend, clear pend_v, cnt=0, stay in SHIFT;
    - else if an input transfer happens in the same cycle: load sh from in_data, cnt=0, stay in SHIFT;
    - else go to IDLE.
  - Input transfer in SHIFT without a simultaneous last-bit transfer: write pend, set pend_v=1.
- Stall: while bit_ready=0, bit_out, bit_first, bit_last and bit_valid stay stable. bit_valid never drops once asserted until the last-bit transfer completes.
- Throughput: one bit per cycle when bit_ready=1. No bubble between words.
- busy = (state==SHIFT) || pend_v.
- in_data is don't-care when in_valid=0. An in_valid held with in_ready=0 is not consumed.
- Reset mid-word: the partially sent word and the pending word are discarded. No bit_valid on the first cycle after reset is released.

Decomposition:
- Shared package fsm_pkg holds:
  - WORD_W = 8, the default width;
  - the state encoding: ST_IDLE = 1'b0, ST_SHIFT = 1'b1.
- Sub-module ser_shift_reg holds the shift register, bit counter and first/last decode. Ports: load, load_data, shift_en, bit_out, first, last.
- The parent holds the FSM, the pending buffer and the handshake logic.

Test Plan:
- Single word, LSB-first: in_data=23 (00010111), bit_ready=1 → bit_valid high for 8 cycles starting 1 cycle after accept; bits 1,1,1,0,1,0,0,0; bit_first on bit 0, bit_last on bit 7; then IDLE, busy=0.
- Back-to-back words: send 23, then 170 while the first word is shifting → pend_v set, in_ready=0 until 170 loads. 16 consecutive valid bits: 1,1,1,0,1,0,0,0,0,1,0,1,0,1,0,1. No gap.
- Stall: send 74 (01001010), drop bit_ready for 4 cycles at bit index 3 → bit_out=1 and bit_valid=1 held all 4 cycles; stream resumes with bits 0,0,1,0.
- MSB_FIRST=1: send 110 (01101110) → bits 0,1,1,0,1,1,1,0. bit_last is asserted with the final 0.
- Reset mid-word: accept 200 plus a pending 122, assert rst_n=0 after 3 bits → outputs clear immediately, in_ready=1. After release, sending 65 produces exactly 8 bits (1,0,0,0,0,0,1,0) and no residue from 200 or 122.
- Simultaneous events: pend empty, last-bit transfer and input transfer in the same cycle (word 33) → 33's bit 0 appears the next cycle; pend_v stays 0.
